// File: rtl/tictactoe_pkg.sv
// Shared tic-tac-toe types: cell encoding, board geometry and scheduler states.
package tictactoe_pkg;

    localparam int N_CELLS = 9;
    localparam int POS_W   = 4;

    typedef enum logic [1:0] {
        EMPTY  = 2'b00,
        X_MARK = 2'b01,
        O_MARK = 2'b10
    } cell_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_P_WAIT,
        S_P_WRITE,
        S_C_DELAY,
        S_C_SCAN,
        S_C_WRITE
    } sched_state_t;

endpackage

// File: rtl/move_scheduler.sv
// Sequences board writes for player moves (handshake + legality check) and
// computer moves (think delay, then first-empty-cell scan).
module move_scheduler #(
    parameter int N_CELLS        = tictactoe_pkg::N_CELLS,
    parameter int POS_W          = tictactoe_pkg::POS_W,
    parameter int COMPUTER_DELAY = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 player_play,
    input  logic                 computer_play,
    input  logic                 player_valid,
    input  logic [POS_W-1:0]     player_pos,
    output logic                 player_ready,
    input  logic [2*N_CELLS-1:0] board_state,
    output logic                 wr_en,
    output logic [POS_W-1:0]     wr_pos,
    output logic [1:0]           wr_mark,
    output logic                 play,
    output logic                 pc,
    output logic                 illegal_move,
    output logic                 no_space
);
    import tictactoe_pkg::*;

    localparam int CNT_W = (COMPUTER_DELAY > 1) ? $clog2(COMPUTER_DELAY) : 1;

    sched_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [POS_W-1:0] idx_q, idx_d;
    logic             wr_en_q, wr_en_d;
    logic [POS_W-1:0] wr_pos_q, wr_pos_d;
    logic [1:0]       wr_mark_q, wr_mark_d;
    logic             play_q, play_d;
    logic             pc_q, pc_d;
    logic             illegal_q, illegal_d;
    logic             no_space_q, no_space_d;

    logic             player_cell_empty;
    logic             scan_cell_empty;

    // Out-of-range positions read garbage here, but they are rejected before use.
    assign player_cell_empty = (cell_t'(board_state[{player_pos, 1'b0} +: 2]) == EMPTY);
    assign scan_cell_empty   = (cell_t'(board_state[{idx_q, 1'b0} +: 2]) == EMPTY);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        wr_en_d    = 1'b0;
        wr_pos_d   = wr_pos_q;
        wr_mark_d  = wr_mark_q;
        play_d     = 1'b0;
        pc_d       = 1'b0;
        illegal_d  = 1'b0;

        no_space_d = 1'b1;
        for (int i = 0; i < N_CELLS; i++) begin
            if (cell_t'(board_state[2*i +: 2]) == EMPTY) no_space_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                if (player_play) begin
                    state_d = S_P_WAIT;
                end else if (computer_play) begin
                    if (COMPUTER_DELAY == 0) begin
                        state_d = S_C_SCAN;
                        idx_d   = '0;
                    end else begin
                        state_d = S_C_DELAY;
                        cnt_d   = CNT_W'(COMPUTER_DELAY - 1);
                    end
                end
            end
            S_P_WAIT: begin
                // Losing the enable wins over a simultaneous handshake.
                if (!player_play) begin
                    state_d = S_IDLE;
                end else if (player_valid) begin
                    if (player_pos >= POS_W'(N_CELLS) || !player_cell_empty) begin
                        illegal_d = 1'b1;
                    end else begin
                        state_d   = S_P_WRITE;
                        wr_en_d   = 1'b1;
                        wr_pos_d  = player_pos;
                        wr_mark_d = X_MARK;
                        play_d    = 1'b1;
                    end
                end
            end
            S_C_DELAY: begin
                if (!computer_play) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = S_C_SCAN;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_C_SCAN: begin
                if (!computer_play) begin
                    state_d = S_IDLE;
                end else if (scan_cell_empty) begin
                    state_d   = S_C_WRITE;
                    wr_en_d   = 1'b1;
                    wr_pos_d  = idx_q;
                    wr_mark_d = O_MARK;
                    pc_d      = 1'b1;
                end else if (idx_q == POS_W'(N_CELLS - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    idx_d = idx_q + POS_W'(1);
                end
            end
            S_P_WRITE, S_C_WRITE: state_d = S_IDLE;
            default:              state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_pos_q   <= '0;
            wr_mark_q  <= '0;
            play_q     <= 1'b0;
            pc_q       <= 1'b0;
            illegal_q  <= 1'b0;
            no_space_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            wr_en_q    <= wr_en_d;
            wr_pos_q   <= wr_pos_d;
            wr_mark_q  <= wr_mark_d;
            play_q     <= play_d;
            pc_q       <= pc_d;
            illegal_q  <= illegal_d;
            no_space_q <= no_space_d;
        end
    end

    assign player_ready = (state_q == S_P_WAIT);
    assign wr_en        = wr_en_q;
    assign wr_pos       = wr_pos_q;
    assign wr_mark      = wr_mark_q;
    assign play         = play_q;
    assign pc           = pc_q;
    assign illegal_move = illegal_q;
    assign no_space     = no_space_q;

endmodule

// File: tb/tb_move_scheduler.sv
// Scoreboard bench for move_scheduler: drivers predict events from a board model,
// a negedge monitor pops and compares every strobe the DUT produces.
module tb_move_scheduler;

    localparam int D = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        player_play, computer_play, player_valid;
    logic [3:0]  player_pos;
    logic        player_ready;
    logic [17:0] board_state;
    logic        wr_en;
    logic [3:0]  wr_pos;
    logic [1:0]  wr_mark;
    logic        play, pc, illegal_move, no_space;

    logic [1:0]  board [9];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic       wr, pl, pcv, ill;
        logic [3:0] pos;
        logic [1:0] mark;
        int         c;
    } exp_t;
    exp_t sbq[$];
    exp_t e;

    move_scheduler #(.N_CELLS(9), .POS_W(4), .COMPUTER_DELAY(D)) dut (
        .clock(clk), .reset(reset),
        .player_play(player_play), .computer_play(computer_play),
        .player_valid(player_valid), .player_pos(player_pos),
        .player_ready(player_ready), .board_state(board_state),
        .wr_en(wr_en), .wr_pos(wr_pos), .wr_mark(wr_mark),
        .play(play), .pc(pc), .illegal_move(illegal_move), .no_space(no_space)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        board_state = '0;
        for (int i = 0; i < 9; i++) board_state[2*i +: 2] = board[i];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic wr, input logic pl, input logic pcv, input logic ill,
                            input int pos, input logic [1:0] mark, input int c);
        exp_t x;
        x.wr = wr; x.pl = pl; x.pcv = pcv; x.ill = ill;
        x.pos = 4'(pos); x.mark = mark; x.c = c;
        sbq.push_back(x);
    endtask

    function automatic bit board_full();
        for (int i = 0; i < 9; i++) if (board[i] == 2'b00) return 1'b0;
        return 1'b1;
    endfunction

    // Edge-indexed timing: a strobe registered at edge n is seen with cyc==n.
    always @(negedge clk) begin
        if (!reset && (wr_en || play || pc || illegal_move)) begin
            if (sbq.size() == 0) begin
                check("unexpected_event", {28'd0, wr_en, play, pc, illegal_move}, 32'd0);
            end else begin
                e = sbq.pop_front();
                check("event_kind", {28'd0, wr_en, play, pc, illegal_move},
                      {28'd0, e.wr, e.pl, e.pcv, e.ill});
                check("event_cycle", cyc, e.c);
                if (e.wr) begin
                    check("wr_pos", {28'd0, wr_pos}, {28'd0, e.pos});
                    check("wr_mark", {30'd0, wr_mark}, {30'd0, e.mark});
                end
            end
        end
    end

    task automatic player_begin(input bit both);
        player_play = 1'b1;
        if (both) computer_play = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (player_ready) break;
        end
        check("ready_rise", {31'd0, player_ready}, 32'd1);
    endtask

    task automatic player_offer(input int pos, output bit ok);
        bit legal;
        int t;
        legal = (pos < 9) && (board[pos] == 2'b00);
        player_valid = 1'b1;
        player_pos   = 4'(pos);
        t = cyc + 1;
        push_exp(legal, legal, 1'b0, !legal, pos, 2'b01, t);
        tick();
        player_valid = 1'b0;
        player_pos   = 4'($urandom_range(0, 15));
        if (legal) begin
            check("ready_in_write", {31'd0, player_ready}, 32'd0);
            board[pos] = 2'b01;
        end else begin
            check("ready_after_illegal", {31'd0, player_ready}, 32'd1);
        end
        ok = legal;
    endtask

    task automatic player_end();
        player_play   = 1'b0;
        computer_play = 1'b0;
        tick();
        tick();
    endtask

    // abort_at >= 0: drop computer_play so the scan is abandoned at index abort_at.
    task automatic computer_move(input int abort_at);
        int t, k;
        k = -1;
        for (int i = 0; i < 9; i++) if (board[i] == 2'b00 && k < 0) k = i;
        computer_play = 1'b1;
        t = cyc + 1;
        if (abort_at >= 0) begin
            while (cyc < t + D + abort_at) tick();
            computer_play = 1'b0;
        end else if (k >= 0) begin
            push_exp(1'b1, 1'b0, 1'b1, 1'b0, k, 2'b10, t + D + k + 1);
            while (cyc < t + D + k + 1) tick();
            board[k] = 2'b10;
            computer_play = 1'b0;
        end else begin
            while (cyc < t + D + 9) tick();
            computer_play = 1'b0;
        end
        tick();
        tick();
    endtask

    task automatic clear_board();
        for (int i = 0; i < 9; i++) board[i] = 2'b00;
    endtask

    initial begin
        bit ok;
        int t0;
        reset = 1'b1;
        player_play = 1'b0; computer_play = 1'b0; player_valid = 1'b0; player_pos = '0;
        clear_board();
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready",   {31'd0, player_ready}, 32'd0);
        check("rst_wr_en",   {31'd0, wr_en}, 32'd0);
        check("rst_wr_pos",  {28'd0, wr_pos}, 32'd0);
        check("rst_wr_mark", {30'd0, wr_mark}, 32'd0);
        check("rst_play",    {31'd0, play}, 32'd0);
        check("rst_pc",      {31'd0, pc}, 32'd0);
        check("rst_illegal", {31'd0, illegal_move}, 32'd0);
        check("rst_no_space",{31'd0, no_space}, 32'd0);
        reset = 1'b0;
        tick();

        // Legal player move on an empty board.
        player_begin(1'b0);
        player_offer(4, ok);
        player_end();

        // Occupied cell, out-of-range position, then a legal one.
        player_begin(1'b0);
        player_offer(4, ok);
        player_offer(9, ok);
        player_offer(0, ok);
        player_end();

        // Computer picks the first empty cell after the think time.
        clear_board();
        board[0] = 2'b01; board[1] = 2'b10; board[2] = 2'b11;
        tick();
        computer_move(-1);

        // Full board raises no_space one edge later; computer scan writes nothing.
        for (int i = 0; i < 9; i++) board[i] = (i == 5) ? 2'b11 : 2'(1 + (i % 2));
        check("no_space_lag", {31'd0, no_space}, 32'd0);
        tick();
        check("no_space_full", {31'd0, no_space}, 32'd1);
        computer_move(-1);
        check("no_space_hold", {31'd0, no_space}, 32'd1);

        // Both enables high: player wins.
        clear_board();
        tick();
        check("no_space_clear", {31'd0, no_space}, 32'd0);
        player_begin(1'b1);
        player_offer(2, ok);
        player_end();

        // computer_play dropped mid-scan: no write.
        for (int i = 0; i < 6; i++) board[i] = 2'b01;
        computer_move(2);

        // Async reset during a scan clears all registered outputs at once.
        clear_board();
        player_begin(1'b0);
        player_offer(5, ok);
        player_end();
        for (int i = 0; i < 8; i++) if (board[i] == 2'b00) board[i] = 2'b10;
        computer_play = 1'b1;
        t0 = cyc + 1;
        while (cyc < t0 + D + 3) tick();
        #2 reset = 1'b1;
        #1;
        check("arst_wr_pos",  {28'd0, wr_pos}, 32'd0);
        check("arst_wr_mark", {30'd0, wr_mark}, 32'd0);
        check("arst_ready",   {31'd0, player_ready}, 32'd0);
        check("arst_wr_en",   {31'd0, wr_en}, 32'd0);
        computer_play = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        clear_board();
        player_begin(1'b0);
        player_offer(7, ok);
        player_end();

        // Randomized mix against the board model.
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < 9; i++)
                board[i] = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            tick();
            check("rand_no_space", {31'd0, no_space}, {31'd0, board_full()});
            case ($urandom_range(0, 2))
                0: begin
                    player_begin($urandom_range(0, 3) == 0);
                    ok = 1'b0;
                    for (int a = 0; a < 3 && !ok; a++) player_offer($urandom_range(0, 10), ok);
                    player_end();
                end
                1: computer_move(-1);
                default: begin
                    int k;
                    k = -1;
                    for (int i = 0; i < 9; i++) if (board[i] == 2'b00 && k < 0) k = i;
                    computer_move((k > 0) ? int'($urandom_range(0, k - 1)) : -1);
                end
            endcase
        end

        tick();
        check("sb_empty", sbq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
